// File: rtl/ddr2_pkg.sv
// Shared definitions for the DDR2 request arbiter: FSM encoding, port indices,
// and the round-robin pointer update.
package ddr2_pkg;
  localparam int ADDR_W = 27;
  localparam int PORT_AW = 19;

  localparam int PRG = 0;
  localparam int CHR = 1;
  localparam int SD  = 2;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT_BUSY,
    ST_WAIT_DONE
  } state_e;

  // Next round starts at the port after the one just granted.
  function automatic logic [1:0] rr_after(input logic [2:0] gnt);
    logic [1:0] nxt;
    nxt = 2'd0;
    if (gnt[PRG])      nxt = 2'd1;
    else if (gnt[CHR]) nxt = 2'd2;
    return nxt;
  endfunction
endpackage

// File: rtl/rr_arbiter3.sv
// Three-way round-robin picker: the pointer names the highest-priority port,
// and the output is a one-hot grant (zero when nothing is pending).
module rr_arbiter3
  import ddr2_pkg::*;
(
  input  logic [2:0] i_pend,
  input  logic [1:0] i_ptr,
  output logic [2:0] o_gnt
);

  logic [1:0] w_p0, w_p1, w_p2;

  always_comb begin
    w_p0 = 2'(PRG);
    w_p1 = 2'(CHR);
    w_p2 = 2'(SD);
    case (i_ptr)
      2'd1: begin w_p0 = 2'(CHR); w_p1 = 2'(SD);  w_p2 = 2'(PRG); end
      2'd2: begin w_p0 = 2'(SD);  w_p1 = 2'(PRG); w_p2 = 2'(CHR); end
      default: ;
    endcase
  end

  always_comb begin
    o_gnt = '0;
    if (i_pend[w_p0])      o_gnt[w_p0] = 1'b1;
    else if (i_pend[w_p1]) o_gnt[w_p1] = 1'b1;
    else if (i_pend[w_p2]) o_gnt[w_p2] = 1'b1;
  end

endmodule

// File: rtl/ddr2_request_arbiter.sv
// Shares one DDR2 controller UI between PRG/CHR byte readers and an SD byte
// writer; one pending slot per port, one controller transaction at a time.
module ddr2_request_arbiter
  import ddr2_pkg::*;
#(
  parameter logic [ADDR_W-1:0] CHR_BASE_ADDR  = 27'h0080000,
  parameter int                TIMEOUT_CYCLES = 1023
) (
  input  logic               ui_clk_i,
  input  logic               ui_rst_n_i,
  input  logic               prg_rd_req_i,
  input  logic [PORT_AW-1:0] prg_rd_addr_i,
  output logic [7:0]         prg_rd_data_o,
  output logic               prg_rd_valid_o,
  input  logic               chr_rd_req_i,
  input  logic [PORT_AW-1:0] chr_rd_addr_i,
  output logic [7:0]         chr_rd_data_o,
  output logic               chr_rd_valid_o,
  input  logic               sd_wr_valid_i,
  input  logic [PORT_AW-1:0] sd_wr_addr_i,
  input  logic [7:0]         sd_wr_data_i,
  output logic               sd_wr_ready_o,
  input  logic               cntrl_idle_i,
  output logic               cntrl_rd_req_o,
  output logic               cntrl_wr_req_o,
  output logic [ADDR_W-1:0]  cntrl_addr_o,
  output logic [7:0]         cntrl_wr_data_o,
  input  logic [7:0]         cntrl_rd_data_i,
  input  logic               cntrl_rd_valid_i,
  output logic               timeout_err_o
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYCLES - 1);

  state_e             r_state, w_state_nxt;
  logic               r_prg_pend, r_chr_pend, r_sd_pend, w_sd_pend_nxt;
  logic [PORT_AW-1:0] r_prg_addr, r_chr_addr, r_sd_addr;
  logic [7:0]         r_sd_data;
  logic               r_sd_ready;
  logic [2:0]         r_gnt, w_gnt, w_pend;
  logic [1:0]         r_rr_ptr;
  logic [CNT_W-1:0]   r_cnt;
  logic [7:0]         r_prg_data, r_chr_data;
  logic               r_prg_valid, r_chr_valid, r_timeout;
  logic               w_grant, w_issue, w_done_rd, w_tmo, w_is_rd, w_sd_acc;
  logic [ADDR_W-1:0]  w_cmd_addr;

  assign w_pend   = {r_sd_pend, r_chr_pend, r_prg_pend};
  assign w_is_rd  = r_gnt[PRG] | r_gnt[CHR];
  assign w_sd_acc = sd_wr_valid_i & r_sd_ready;

  rr_arbiter3 u_rr (
    .i_pend (w_pend),
    .i_ptr  (r_rr_ptr),
    .o_gnt  (w_gnt)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_grant     = 1'b0;
    w_issue     = 1'b0;
    w_done_rd   = 1'b0;
    w_tmo       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (cntrl_idle_i && |w_pend) begin
          w_grant     = 1'b1;
          w_state_nxt = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        w_issue     = 1'b1;
        w_state_nxt = ST_WAIT_BUSY;
      end
      ST_WAIT_BUSY: begin
        // A fast controller may return read data before idle is ever seen low.
        if (w_is_rd && cntrl_rd_valid_i) begin
          w_done_rd   = 1'b1;
          w_state_nxt = ST_IDLE;
        end else if (r_cnt == CNT_MAX) begin
          w_tmo       = 1'b1;
          w_state_nxt = ST_IDLE;
        end else if (!cntrl_idle_i) begin
          w_state_nxt = ST_WAIT_DONE;
        end
      end
      ST_WAIT_DONE: begin
        if (w_is_rd ? cntrl_rd_valid_i : cntrl_idle_i) begin
          w_done_rd   = w_is_rd;
          w_state_nxt = ST_IDLE;
        end else if (r_cnt == CNT_MAX) begin
          w_tmo       = 1'b1;
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    w_cmd_addr = {8'h00, r_prg_addr};
    if (r_gnt[CHR])     w_cmd_addr = {8'h00, r_chr_addr} + CHR_BASE_ADDR;
    else if (r_gnt[SD]) w_cmd_addr = {8'h00, r_sd_addr};
  end

  assign cntrl_rd_req_o  = w_issue & w_is_rd;
  assign cntrl_wr_req_o  = w_issue & r_gnt[SD];
  assign cntrl_addr_o    = w_issue ? w_cmd_addr : '0;
  assign cntrl_wr_data_o = (w_issue & r_gnt[SD]) ? r_sd_data : 8'h00;

  // A new request in the grant's issue cycle wins over the slot clear.
  assign w_sd_pend_nxt = w_sd_acc ? 1'b1 : (w_issue & r_gnt[SD]) ? 1'b0 : r_sd_pend;

  always_ff @(posedge ui_clk_i or negedge ui_rst_n_i) begin
    if (!ui_rst_n_i) begin
      r_state    <= ST_IDLE;
      r_prg_pend <= 1'b0;
      r_chr_pend <= 1'b0;
      r_sd_pend  <= 1'b0;
      r_prg_addr <= '0;
      r_chr_addr <= '0;
      r_sd_addr  <= '0;
      r_sd_data  <= '0;
      r_sd_ready <= 1'b0;
      r_gnt      <= '0;
      r_rr_ptr   <= 2'(PRG);
      r_cnt      <= '0;
    end else begin
      r_state <= w_state_nxt;

      if (prg_rd_req_i) begin
        r_prg_pend <= 1'b1;
        r_prg_addr <= prg_rd_addr_i;
      end else if (w_issue && r_gnt[PRG]) begin
        r_prg_pend <= 1'b0;
      end

      if (chr_rd_req_i) begin
        r_chr_pend <= 1'b1;
        r_chr_addr <= chr_rd_addr_i;
      end else if (w_issue && r_gnt[CHR]) begin
        r_chr_pend <= 1'b0;
      end

      r_sd_pend  <= w_sd_pend_nxt;
      r_sd_ready <= ~w_sd_pend_nxt;
      if (w_sd_acc) begin
        r_sd_addr <= sd_wr_addr_i;
        r_sd_data <= sd_wr_data_i;
      end

      if (w_grant) begin
        r_gnt    <= w_gnt;
        r_rr_ptr <= rr_after(w_gnt);
      end

      if (w_issue)
        r_cnt <= '0;
      else if (r_state == ST_WAIT_BUSY || r_state == ST_WAIT_DONE)
        r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge ui_clk_i or negedge ui_rst_n_i) begin
    if (!ui_rst_n_i) begin
      r_prg_data  <= '0;
      r_chr_data  <= '0;
      r_prg_valid <= 1'b0;
      r_chr_valid <= 1'b0;
      r_timeout   <= 1'b0;
    end else begin
      r_prg_valid <= w_done_rd & r_gnt[PRG];
      r_chr_valid <= w_done_rd & r_gnt[CHR];
      if (w_done_rd && r_gnt[PRG]) r_prg_data <= cntrl_rd_data_i;
      if (w_done_rd && r_gnt[CHR]) r_chr_data <= cntrl_rd_data_i;
      if (w_tmo) r_timeout <= 1'b1;
    end
  end

  assign prg_rd_data_o  = r_prg_data;
  assign prg_rd_valid_o = r_prg_valid;
  assign chr_rd_data_o  = r_chr_data;
  assign chr_rd_valid_o = r_chr_valid;
  assign sd_wr_ready_o  = r_sd_ready;
  assign timeout_err_o  = r_timeout;

endmodule

// File: doc/ddr2_request_arbiter.md
DDR2_REQUEST_ARBITER -- requirements
Module: ddr2_request_arbiter

Interface
REQ-001 Parameter CHR_BASE_ADDR, default 27'h0080000: DDR byte offset added to every CHR read address.
REQ-002 Parameter TIMEOUT_CYCLES, default 1023: maximum cycles spent waiting on the controller per transaction.
REQ-003 ui_clk_i  in  1  sole clock, the DDR2 controller UI clock; all logic on its rising edge.
REQ-004 ui_rst_n_i  in  1  reset, asynchronous assert, active-low.
REQ-005 prg_rd_req_i  in  1  one-cycle PRG read request pulse.
REQ-006 prg_rd_addr_i  in  19  PRG byte address, sampled with prg_rd_req_i.
REQ-007 prg_rd_data_o  out  8  PRG read data, held until next PRG completion.
REQ-008 prg_rd_valid_o  out  1  one-cycle PRG data strobe.
REQ-009 chr_rd_req_i / chr_rd_addr_i / chr_rd_data_o / chr_rd_valid_o  in/in/out/out  1/19/8/1  CHR read port; same semantics as PRG.
REQ-010 sd_wr_valid_i  in  1  SD write request, held until accepted.
REQ-011 sd_wr_addr_i  in  19  SD write byte address.
REQ-012 sd_wr_data_i  in  8  SD write data.
REQ-013 sd_wr_ready_o  out  1  SD slot empty; a write is accepted on cycle valid&&ready.
REQ-014 cntrl_idle_i  in  1  controller idle (cntrl_iface_is_idle).
REQ-015 cntrl_rd_req_o / cntrl_wr_req_o  out  1  one-cycle controller command pulses.
REQ-016 cntrl_addr_o  out  27  controller address, valid with command pulse.
REQ-017 cntrl_wr_data_o  out  8  controller write data, valid with cntrl_wr_req_o.
REQ-018 cntrl_rd_data_i / cntrl_rd_valid_i  in  8/1  controller read return.
REQ-019 timeout_err_o  out  1  sticky timeout flag.

Function
REQ-020 Each port has one pending slot (flag + address [+ data]); PRG/CHR slot loads on req pulse, SD slot on valid&&ready.
REQ-021 A read req arriving while that port's slot is pending overwrites the address; flag stays set.
REQ-022 A req arriving in the same cycle its slot is granted re-sets the slot with the new address.
REQ-023 Arbitration: round-robin PRG->CHR->SD, starting after the last granted port; first after reset is PRG.
REQ-024 FSM states: IDLE, ISSUE, WAIT_BUSY, WAIT_DONE.
REQ-025 IDLE: if cntrl_idle_i=1 and any slot pending -> latch grant, go ISSUE; otherwise stay.
REQ-026 ISSUE (exactly one cycle): pulse the matching command; cntrl_addr_o = {8'h0,addr} for PRG/SD, {8'h0,addr}+CHR_BASE_ADDR (27-bit, wraps) for CHR; clear granted slot; go WAIT_BUSY.
REQ-027 WAIT_BUSY: on cntrl_idle_i=0 go WAIT_DONE; a read with cntrl_rd_valid_i already high completes directly (REQ-029).
REQ-028 WAIT_DONE, write: on cntrl_idle_i=1 -> IDLE.
REQ-029 WAIT_DONE, read: on cntrl_rd_valid_i -> register data to the granted port, pulse its valid next cycle, -> IDLE; read latency command->port valid = controller latency + 1.
REQ-030 cntrl_rd_valid_i outside a read wait is ignored.
REQ-031 Timeout counter clears on entering WAIT_BUSY; if TIMEOUT_CYCLES elapse in WAIT_BUSY/WAIT_DONE -> set timeout_err_o, no port valid, -> IDLE.
REQ-032 sd_wr_ready_o = ~SD slot pending (registered); command outputs are zero outside ISSUE.

Reset
REQ-033 ui_rst_n_i low: FSM IDLE, all slots cleared, rr pointer = PRG, counter 0; all outputs 0 except sd_wr_ready_o=0 until the first cycle after deassertion, then 1.
REQ-034 Reset mid-transaction abandons it; no valid pulse follows release.

Structure
REQ-035 Shared package ddr2_pkg holds FSM state encoding, port index constants (PRG=0, CHR=1, SD=2) and the 27-bit address width.
REQ-036 One sub-module rr_arbiter3 (pending vector + last grant -> one-hot grant, combinational); everything else in the top.

Verification
REQ-037 PRG req addr 19'h00010, controller returns 8'hA5 -> cntrl_rd_req_o with addr 27'h0000010, prg_rd_valid_o with 8'hA5, chr_rd_valid_o stays 0.
REQ-038 CHR req addr 19'h00003 -> cntrl_addr_o 27'h0080003; data routed only to chr_rd_data_o.
REQ-039 PRG, CHR, SD all pending same cycle -> grant order PRG, CHR, SD; next round starts after SD.
REQ-040 SD write valid held with ready=0 during busy -> accepted once ready returns; exactly one cntrl_wr_req_o per accepted byte.
REQ-041 Controller never drops idle after command -> timeout_err_o set after 1023 cycles, FSM back in IDLE, later request served.
REQ-042 Reset asserted in WAIT_DONE of a read -> all outputs 0, no prg_rd_valid_o after release even if cntrl_rd_valid_i pulses.
